dmem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single-port synchronous data memory of riscv_singlecycle between the core load/store unit (port 0) and the host/debug read-write port (port 1).
- Round-robin grant with combinational same-cycle grant, 1-cycle registered response routing, and address-window checking.
- The core treats !c_gnt_o with c_req_i high as a stall, holding its PC and register-file write enable.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_rr_arb2.sv | 20 ++
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types, port indices and saturating counter helper for dmem_arbiter
package dmem_arb_pkg;
    localparam int PORT_CORE = 0;
    localparam int PORT_HOST = 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } mem_rsp_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return v + 32'(en && (v != '1));
    endfunction
endpackage

// File: rtl/dmem_rr_arb2.sv
// dmem_rr_arb2: 2-way round-robin arbiter, combinational grant, last winner loses next tie
module dmem_rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       prio_q
);
    assign gnt[PORT_CORE] = req[PORT_CORE] & (~req[PORT_HOST] | ~prio_q);
    assign gnt[PORT_HOST] = req[PORT_HOST] & (~req[PORT_CORE] | prio_q);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            prio_q <= 1'b0;
        else if (|req)
            prio_q <= gnt[PORT_CORE];
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core/host data-memory arbiter with window check; DMEM_ARB_PERF_EN adds grant/conflict counters
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter logic [31:0] MEM_BASE = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE = 32'h0001_0000,
    localparam int         AW       = $clog2(MEM_SIZE / 4)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          c_req_i,
    input  logic          c_we_i,
    input  logic [31:0]   c_addr_i,
    input  logic [31:0]   c_wdata_i,
    input  logic [3:0]    c_be_i,
    output logic          c_gnt_o,
    output logic          c_rvalid_o,
    output logic [31:0]   c_rdata_o,
    output logic          c_err_o,
    input  logic          h_req_i,
    input  logic          h_we_i,
    input  logic [31:0]   h_addr_i,
    input  logic [31:0]   h_wdata_i,
    input  logic [3:0]    h_be_i,
    output logic          h_gnt_o,
    output logic          h_rvalid_o,
    output logic [31:0]   h_rdata_o,
    output logic          h_err_o,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]   c_grant_cnt_o,
    output logic [31:0]   h_grant_cnt_o,
    output logic [31:0]   conflict_cnt_o,
`endif
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic [3:0]    mem_be_o,
    input  logic [31:0]   mem_rdata_i
);
    mem_req_t    c_req, h_req, sel;
    mem_rsp_t    c_rsp, h_rsp;
    logic [1:0]  gnt;
    logic        prio_q, granted, in_range;
    logic [31:0] off;
    logic        resp_valid_q, resp_owner_q, resp_err_q, resp_rd_q;

    assign c_req = '{we: c_we_i, addr: c_addr_i, wdata: c_wdata_i, be: c_be_i};
    assign h_req = '{we: h_we_i, addr: h_addr_i, wdata: h_wdata_i, be: h_be_i};

    dmem_rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req    ({h_req_i, c_req_i}),
        .gnt    (gnt),
        .prio_q (prio_q)
    );

    assign c_gnt_o  = gnt[PORT_CORE];
    assign h_gnt_o  = gnt[PORT_HOST];
    assign granted  = |gnt;
    assign sel      = gnt[PORT_HOST] ? h_req : c_req;
    // Unsigned wrap makes addresses below the base fail the window check
    assign off      = sel.addr - MEM_BASE;
    assign in_range = off < MEM_SIZE;

    assign mem_req_o   = granted & in_range;
    assign mem_we_o    = mem_req_o & sel.we;
    assign mem_addr_o  = mem_req_o ? off[AW+1:2] : '0;
    assign mem_wdata_o = mem_req_o ? sel.wdata : '0;
    assign mem_be_o    = mem_req_o ? sel.be : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rd_q    <= 1'b0;
        end else begin
            resp_valid_q <= granted;
            resp_owner_q <= gnt[PORT_HOST];
            resp_err_q   <= granted & ~in_range;
            resp_rd_q    <= granted & in_range & ~sel.we;
        end
    end

    always_comb begin
        c_rsp.rvalid = resp_valid_q & ~resp_owner_q;
        h_rsp.rvalid = resp_valid_q & resp_owner_q;
        c_rsp.rdata  = (c_rsp.rvalid & resp_rd_q) ? mem_rdata_i : '0;
        h_rsp.rdata  = (h_rsp.rvalid & resp_rd_q) ? mem_rdata_i : '0;
        c_rsp.err    = c_rsp.rvalid & resp_err_q;
        h_rsp.err    = h_rsp.rvalid & resp_err_q;
    end

    assign c_rvalid_o = c_rsp.rvalid;
    assign c_rdata_o  = c_rsp.rdata;
    assign c_err_o    = c_rsp.err;
    assign h_rvalid_o = h_rsp.rvalid;
    assign h_rdata_o  = h_rsp.rdata;
    assign h_err_o    = h_rsp.err;

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            c_grant_cnt_o  <= '0;
            h_grant_cnt_o  <= '0;
            conflict_cnt_o <= '0;
        end else begin
            c_grant_cnt_o  <= sat_inc(c_grant_cnt_o, gnt[PORT_CORE]);
            h_grant_cnt_o  <= sat_inc(h_grant_cnt_o, gnt[PORT_HOST]);
            conflict_cnt_o <= sat_inc(conflict_cnt_o, c_req_i & h_req_i);
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with a byte-enable memory model
module tb_dmem_arbiter;
    localparam int AW = 14;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req_i, c_we_i, h_req_i, h_we_i;
    logic [31:0]   c_addr_i, c_wdata_i, h_addr_i, h_wdata_i;
    logic [3:0]    c_be_i, h_be_i;
    logic          c_gnt_o, c_rvalid_o, c_err_o, h_gnt_o, h_rvalid_o, h_err_o;
    logic [31:0]   c_rdata_o, h_rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o, mem_rdata_i;
    logic [3:0]    mem_be_o;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]   c_grant_cnt_o, h_grant_cnt_o, conflict_cnt_o;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [31:0] mem [16];

    dmem_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .c_req_i(c_req_i), .c_we_i(c_we_i), .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i), .c_be_i(c_be_i),
        .c_gnt_o(c_gnt_o), .c_rvalid_o(c_rvalid_o), .c_rdata_o(c_rdata_o), .c_err_o(c_err_o),
        .h_req_i(h_req_i), .h_we_i(h_we_i), .h_addr_i(h_addr_i), .h_wdata_i(h_wdata_i), .h_be_i(h_be_i),
        .h_gnt_o(h_gnt_o), .h_rvalid_o(h_rvalid_o), .h_rdata_o(h_rdata_o), .h_err_o(h_err_o),
`ifdef DMEM_ARB_PERF_EN
        .c_grant_cnt_o(c_grant_cnt_o), .h_grant_cnt_o(h_grant_cnt_o), .conflict_cnt_o(conflict_cnt_o),
`endif
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory: 1-cycle read latency, byte-enable merge on write
    always @(posedge clk) begin
        if (rst) begin
            mem[0]  <= 32'h0BAD_F00D;
            mem[1]  <= 32'hAAAA_5555;
            mem[4]  <= 32'h1234_5678;
            mem[15] <= 32'h5A5A_0F0F;
            mem_rdata_i <= '0;
        end else if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) mem[mem_addr_o[3:0]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= mem[mem_addr_o[3:0]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic core(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        c_req_i = r; c_we_i = w; c_addr_i = a; c_wdata_i = d; c_be_i = b;
    endtask

    task automatic host(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        h_req_i = r; h_we_i = w; h_addr_i = a; h_wdata_i = d; h_be_i = b;
    endtask

    task automatic idle;
        core(0, 0, 0, 0, 0);
        host(0, 0, 0, 0, 0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic p, input logic [31:0] d, input logic e);
        sb.push_back('{port: p, rdata: d, err: e});
    endtask

    task automatic gnt_chk(input string n, input logic c, input logic h);
        #1;
        chk({n, "_c_gnt"}, 32'(c_gnt_o), 32'(c));
        chk({n, "_h_gnt"}, 32'(h_gnt_o), 32'(h));
    endtask

    // Monitor: pops the scoreboard whenever a response appears
    always @(negedge clk) begin
        exp_t e;
        if (c_rvalid_o === 1'b1 || h_rvalid_o === 1'b1) begin
            if (c_rvalid_o && h_rvalid_o) begin
                checks++; failures++;
                $display("FAIL rvalid_onehot actual=11 required=one_port");
            end else if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_rvalid actual=c%b_h%b required=none", c_rvalid_o, h_rvalid_o);
            end else begin
                e = sb.pop_front();
                chk("rsp_port", 32'(h_rvalid_o), 32'(e.port));
                chk("rsp_rdata", h_rvalid_o ? h_rdata_o : c_rdata_o, e.rdata);
                chk("rsp_err", 32'(h_rvalid_o ? h_err_o : c_err_o), 32'(e.err));
                chk("rsp_other_rdata", h_rvalid_o ? c_rdata_o : h_rdata_o, 32'h0);
                chk("rsp_other_err", 32'(h_rvalid_o ? c_err_o : h_err_o), 32'h0);
            end
        end else if (!rst) begin
            chk("idle_rdata", c_rdata_o | h_rdata_o, 32'h0);
            chk("idle_err", 32'({c_err_o, h_err_o}), 32'h0);
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_rvalid", 32'({c_rvalid_o, h_rvalid_o}), 32'h0);
        chk("rst_err", 32'({c_err_o, h_err_o}), 32'h0);
        chk("rst_prio", 32'(dut.prio_q), 32'h0);
        chk("idle_mem_req", 32'(mem_req_o), 32'h0);

        // Core-only read of word 4
        core(1, 0, 32'h8000_0010, 0, 4'hF);
        gnt_chk("c_rd", 1, 0);
        chk("c_rd_mem_req", 32'(mem_req_o), 32'h1);
        chk("c_rd_mem_we", 32'(mem_we_o), 32'h0);
        chk("c_rd_mem_addr", 32'(mem_addr_o), 32'h4);
        push(0, 32'h1234_5678, 0);
        tick();

        // Reset in the cycle after a granted read: that response shows, nothing after
        idle();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("rst2_prio", 32'(dut.prio_q), 32'h0);

        // Tie for 4 cycles from reset: C,H,C,H
        core(1, 0, 32'h8000_0010, 0, 4'hF);
        host(1, 0, 32'h8000_0004, 0, 4'hF);
        gnt_chk("tie0", 1, 0); push(0, 32'h1234_5678, 0); tick();
        gnt_chk("tie1", 0, 1);
        chk("tie1_mem_addr", 32'(mem_addr_o), 32'h1);
        push(1, 32'hAAAA_5555, 0); tick();
        gnt_chk("tie2", 1, 0); push(0, 32'h1234_5678, 0); tick();
        gnt_chk("tie3", 0, 1); push(1, 32'hAAAA_5555, 0); tick();
`ifdef DMEM_ARB_PERF_EN
        chk("conflict_cnt", conflict_cnt_o, 32'd4);
        chk("c_grant_cnt", c_grant_cnt_o, 32'd2);
        chk("h_grant_cnt", h_grant_cnt_o, 32'd2);
`endif

        // Host partial write, then core read of the merged word
        idle();
        host(1, 1, 32'h8000_0004, 32'hDEAD_BEEF, 4'b0011);
        gnt_chk("h_wr", 0, 1);
        chk("h_wr_mem_we", 32'(mem_we_o), 32'h1);
        chk("h_wr_mem_be", 32'(mem_be_o), 32'h3);
        chk("h_wr_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        chk("h_wr_mem_addr", 32'(mem_addr_o), 32'h1);
        push(1, 32'h0, 0); tick();
        idle();
        core(1, 0, 32'h8000_0004, 0, 4'hF);
        gnt_chk("c_rd_merged", 1, 0);
        push(0, 32'hAAAA_BEEF, 0); tick();

        // Window boundaries
        core(1, 0, 32'h7FFF_FFFC, 0, 4'hF);
        gnt_chk("below_base", 1, 0);
        chk("below_base_mem_req", 32'(mem_req_o), 32'h0);
        push(0, 32'h0, 1); tick();
        core(1, 0, 32'h8001_0000, 0, 4'hF);
        gnt_chk("above_top", 1, 0);
        chk("above_top_mem_req", 32'(mem_req_o), 32'h0);
        push(0, 32'h0, 1); tick();
        core(1, 0, 32'h8000_FFFE, 0, 4'hF);
        gnt_chk("last_word", 1, 0);
        chk("last_word_mem_addr", 32'(mem_addr_o), 32'h3FFF);
        push(0, 32'h5A5A_0F0F, 0); tick();
        idle();
        host(1, 1, 32'h0000_0000, 32'h1111_1111, 4'hF);
        gnt_chk("h_fault", 0, 1);
        chk("h_fault_mem_we", 32'(mem_we_o), 32'h0);
        push(1, 32'h0, 1); tick();

        // Host alone 3 cycles, then a tie goes to the core
        idle();
        host(1, 0, 32'h8000_0000, 0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            gnt_chk("h_alone", 0, 1); push(1, 32'h0BAD_F00D, 0); tick();
        end
        core(1, 0, 32'h8000_0010, 0, 4'hF);
        gnt_chk("tie_after_host", 1, 0); push(0, 32'h1234_5678, 0); tick();
        core(0, 0, 0, 0, 0);
        gnt_chk("host_held", 0, 1); push(1, 32'h0BAD_F00D, 0); tick();

        // Reset asserted during the grant cycle discards the access
        idle();
        core(1, 0, 32'h8000_0010, 0, 4'hF);
        rst = 1'b1;
        tick();
        idle();
        tick();
        rst = 1'b0;
        chk("rst3_prio", 32'(dut.prio_q), 32'h0);
        chk("rst3_rvalid", 32'({c_rvalid_o, h_rvalid_o}), 32'h0);

        repeat (4) tick();
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
